// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared constants and types for the multi-cycle MIPS controller
// Contents: opcode/funct codes, FSM state encoding, ALU function codes,
// write-select codes, next-PC select codes and the decoded instruction class.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_SLL   = 6'b000000;
    localparam logic [5:0] FN_JR    = 6'b001000;
    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [5:0] FN_SLT   = 6'b101010;

    typedef enum logic [2:0] {
        ST_IF  = 3'd0,
        ST_ID  = 3'd1,
        ST_EX  = 3'd2,
        ST_MEM = 3'd3,
        ST_WB  = 3'd4
    } state_e;

    localparam logic [3:0] ALU_NONE = 4'd0;
    localparam logic [3:0] ALU_ADD  = 4'd1;
    localparam logic [3:0] ALU_SUB  = 4'd2;
    localparam logic [3:0] ALU_AND  = 4'd3;
    localparam logic [3:0] ALU_OR   = 4'd4;
    localparam logic [3:0] ALU_SLT  = 4'd5;
    localparam logic [3:0] ALU_SLL  = 4'd6;

    localparam logic [1:0] WSEL_RD  = 2'b00;
    localparam logic [1:0] WSEL_RT  = 2'b01;
    localparam logic [1:0] WSEL_MEM = 2'b10;
    localparam logic [1:0] WSEL_RA  = 2'b11;

    localparam logic [1:0] PCS_SEQ  = 2'b00;
    localparam logic [1:0] PCS_REG  = 2'b01;
    localparam logic [1:0] PCS_BR   = 2'b10;
    localparam logic [1:0] PCS_JMP  = 2'b11;

    // Instruction class: selects the state path through the FSM.
    typedef enum logic [3:0] {
        K_R, K_IMM, K_LW, K_SW, K_BR, K_J, K_JR, K_JAL, K_ILL
    } kind_e;

    function automatic logic [31:0] ext16(input logic [15:0] v, input logic zext);
        ext16 = zext ? {16'b0, v} : {{16{v[15]}}, v};
    endfunction

endpackage

// File: rtl/mips_decode.sv
// rtl/mips_decode.sv - combinational IR-to-control decode
// Ports: op_i/funct_i/imm16_i (IR slices) in; kind_o (instruction class),
// is_bne_o, alu_op_o, alu_src_o, w_sel_o, imm_data_o out.
// Build option: MIPS_JAL_EN enables jal decode; otherwise jal is illegal.
module mips_decode
    import mips_pkg::*;
(
    input  logic [5:0]  op_i,
    input  logic [5:0]  funct_i,
    input  logic [15:0] imm16_i,
    output kind_e       kind_o,
    output logic        is_bne_o,
    output logic [3:0]  alu_op_o,
    output logic        alu_src_o,
    output logic [1:0]  w_sel_o,
    output logic [31:0] imm_data_o
);

    logic zext;

    always_comb begin
        kind_o    = K_ILL;
        is_bne_o  = 1'b0;
        alu_op_o  = ALU_NONE;
        alu_src_o = 1'b0;
        w_sel_o   = WSEL_RD;
        zext      = 1'b0;
        case (op_i)
            OP_RTYPE: begin
                kind_o = K_R;
                case (funct_i)
                    FN_ADD:  alu_op_o = ALU_ADD;
                    FN_SUB:  alu_op_o = ALU_SUB;
                    FN_AND:  alu_op_o = ALU_AND;
                    FN_OR:   alu_op_o = ALU_OR;
                    FN_SLT:  alu_op_o = ALU_SLT;
                    FN_SLL:  alu_op_o = ALU_SLL;
                    FN_JR:   kind_o   = K_JR;
                    default: kind_o   = K_ILL;
                endcase
            end
            OP_ADDI: begin
                kind_o = K_IMM; alu_op_o = ALU_ADD; alu_src_o = 1'b1; w_sel_o = WSEL_RT;
            end
            OP_ANDI: begin
                kind_o = K_IMM; alu_op_o = ALU_AND; alu_src_o = 1'b1; w_sel_o = WSEL_RT;
                zext = 1'b1;
            end
            OP_ORI: begin
                kind_o = K_IMM; alu_op_o = ALU_OR; alu_src_o = 1'b1; w_sel_o = WSEL_RT;
                zext = 1'b1;
            end
            OP_LW: begin
                kind_o = K_LW; alu_op_o = ALU_ADD; alu_src_o = 1'b1; w_sel_o = WSEL_MEM;
            end
            OP_SW: begin
                kind_o = K_SW; alu_op_o = ALU_ADD; alu_src_o = 1'b1;
            end
            OP_BEQ: begin
                kind_o = K_BR; alu_op_o = ALU_SUB;
            end
            OP_BNE: begin
                kind_o = K_BR; alu_op_o = ALU_SUB; is_bne_o = 1'b1;
            end
            OP_J:    kind_o = K_J;
`ifdef MIPS_JAL_EN
            OP_JAL: begin
                kind_o = K_JAL; w_sel_o = WSEL_RA;
            end
`endif
            default: kind_o = K_ILL;
        endcase
        imm_data_o = ext16(imm16_i, zext);
    end

endmodule

// File: rtl/mips_ctrl.sv
// rtl/mips_ctrl.sv - multi-cycle MIPS control FSM with instruction register
// Ports: clka, rsta (sync active-high), Inst, zero in; PC_s, pc_we, rs, rt, rd,
// imm_data, addressa, alu_op, alu_src, reg_we, w_sel, mem_we, illegal, state out.
// Build option: MIPS_JAL_EN enables jal (ID-WB-IF, writes $31 and jumps).
module mips_ctrl
    import mips_pkg::*;
(
    input  logic        clka,
    input  logic        rsta,
    input  logic [31:0] Inst,
    input  logic        zero,
    output logic [1:0]  PC_s,
    output logic        pc_we,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [31:0] imm_data,
    output logic [25:0] addressa,
    output logic [3:0]  alu_op,
    output logic        alu_src,
    output logic        reg_we,
    output logic [1:0]  w_sel,
    output logic        mem_we,
    output logic        illegal,
    output logic [2:0]  state
);

    state_e      state_q, state_d;
    logic [31:0] ir_q;

    kind_e       kind;
    logic        is_bne;
    logic [3:0]  dec_alu_op;
    logic        pc_we_c, reg_we_c, mem_we_c, illegal_c;
    logic [1:0]  pc_s_c;

    mips_decode u_decode (
        .op_i       (ir_q[31:26]),
        .funct_i    (ir_q[5:0]),
        .imm16_i    (ir_q[15:0]),
        .kind_o     (kind),
        .is_bne_o   (is_bne),
        .alu_op_o   (dec_alu_op),
        .alu_src_o  (alu_src),
        .w_sel_o    (w_sel),
        .imm_data_o (imm_data)
    );

    always_ff @(posedge clka) begin
        if (rsta) begin
            state_q <= ST_IF;
            ir_q    <= 32'h0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_IF) begin
                ir_q <= Inst;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_we_c   = 1'b0;
        pc_s_c    = PCS_SEQ;
        reg_we_c  = 1'b0;
        mem_we_c  = 1'b0;
        illegal_c = 1'b0;
        case (state_q)
            ST_IF: state_d = ST_ID;
            ST_ID: begin
                case (kind)
                    K_ILL: begin
                        illegal_c = 1'b1; pc_we_c = 1'b1; state_d = ST_IF;
                    end
                    K_J: begin
                        pc_we_c = 1'b1; pc_s_c = PCS_JMP; state_d = ST_IF;
                    end
                    K_JR: begin
                        pc_we_c = 1'b1; pc_s_c = PCS_REG; state_d = ST_IF;
                    end
                    K_JAL:   state_d = ST_WB;
                    default: state_d = ST_EX;
                endcase
            end
            ST_EX: begin
                case (kind)
                    K_R, K_IMM: state_d = ST_WB;
                    K_LW, K_SW: state_d = ST_MEM;
                    default: begin
                        // Branch resolves here; anything else finishing in EX just falls through.
                        pc_we_c = 1'b1;
                        if (kind == K_BR && (zero ^ is_bne)) begin
                            pc_s_c = PCS_BR;
                        end
                        state_d = ST_IF;
                    end
                endcase
            end
            ST_MEM: begin
                if (kind == K_SW) begin
                    mem_we_c = 1'b1; pc_we_c = 1'b1; state_d = ST_IF;
                end else begin
                    state_d = ST_WB;
                end
            end
            ST_WB: begin
                reg_we_c = 1'b1;
                pc_we_c  = 1'b1;
                pc_s_c   = (kind == K_JAL) ? PCS_JMP : PCS_SEQ;
                state_d  = ST_IF;
            end
            default: state_d = ST_IF;
        endcase
    end

    // Strobes are masked while rsta is high so an aborted instruction cannot
    // commit a register, memory or PC write on the reset edge.
    assign pc_we    = pc_we_c   & ~rsta;
    assign reg_we   = reg_we_c  & ~rsta;
    assign mem_we   = mem_we_c  & ~rsta;
    assign illegal  = illegal_c & ~rsta;
    assign PC_s     = rsta ? PCS_SEQ : pc_s_c;
    assign alu_op   = (state_q == ST_IF) ? ALU_NONE : dec_alu_op;

    assign rs       = ir_q[25:21];
    assign rt       = ir_q[20:16];
    assign rd       = ir_q[15:11];
    assign addressa = ir_q[25:0];
    assign state    = state_q;

endmodule

// File: tb/tb_mips_ctrl.sv
// tb/tb_mips_ctrl.sv - scoreboard testbench for mips_ctrl
module tb_mips_ctrl;

    localparam int XN = 0, XWS = 1, XIMM = 2, XRT = 3, XRD = 4, XADR = 5, XALU = 6;

    logic        clka = 1'b0;
    logic        rsta = 1'b1;
    logic [31:0] Inst = 32'h0;
    logic        zero = 1'b0;
    logic [1:0]  PC_s;
    logic        pc_we;
    logic [4:0]  rs, rt, rd;
    logic [31:0] imm_data;
    logic [25:0] addressa;
    logic [3:0]  alu_op;
    logic        alu_src;
    logic        reg_we;
    logic [1:0]  w_sel;
    logic        mem_we;
    logic        illegal;
    logic [2:0]  state;

    mips_ctrl dut (
        .clka(clka), .rsta(rsta), .Inst(Inst), .zero(zero),
        .PC_s(PC_s), .pc_we(pc_we), .rs(rs), .rt(rt), .rd(rd),
        .imm_data(imm_data), .addressa(addressa), .alu_op(alu_op),
        .alu_src(alu_src), .reg_we(reg_we), .w_sel(w_sel),
        .mem_we(mem_we), .illegal(illegal), .state(state)
    );

    always #5 clka = ~clka;

    typedef struct {
        int          step;
        logic [8:0]  ctl;
        int          xk;
        logic [31:0] xv;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   nstep = 0;

    // Drive one cycle of stimulus and record what that cycle must look like.
    task automatic cyc(input logic r, input logic [31:0] in, input logic z,
                       input logic [2:0] st, input logic pw, input logic [1:0] ps,
                       input logic rw, input logic mw, input logic il,
                       input int xk, input logic [31:0] xv);
        exp_t e;
        @(posedge clka);
        #1;
        rsta = r;
        Inst = in;
        zero = z;
        e.step = nstep;
        e.ctl  = {st, pw, ps, rw, mw, il};
        e.xk   = xk;
        e.xv   = xv;
        q.push_back(e);
        nstep++;
    endtask

    always @(negedge clka) begin
        if (q.size() != 0) begin
            exp_t e;
            logic [8:0]  act;
            logic [31:0] xa;
            e   = q.pop_front();
            act = {state, pc_we, PC_s, reg_we, mem_we, illegal};
            total++;
            if (act !== e.ctl) begin
                bad++;
                $display("FAIL ctl step=%0d got st/pw/ps/rw/mw/il=%b want=%b", e.step, act, e.ctl);
            end
            if (e.xk != XN) begin
                case (e.xk)
                    XWS:     xa = {30'b0, w_sel};
                    XIMM:    xa = imm_data;
                    XRT:     xa = {27'b0, rt};
                    XRD:     xa = {27'b0, rd};
                    XADR:    xa = {6'b0, addressa};
                    default: xa = {28'b0, alu_op};
                endcase
                total++;
                if (xa !== e.xv) begin
                    bad++;
                    $display("FAIL field%0d step=%0d got=%h want=%h", e.xk, e.step, xa, e.xv);
                end
            end
        end
    end

    initial begin
        // reset: two edges with rsta high
        cyc(1, 32'h0, 0, 3'd0, 0, 2'd0, 0, 0, 0, XALU, 32'h0);
        // NOP (all-zero, sll $0)
        cyc(0, 32'h0, 0, 3'd0, 0, 2'd0, 0, 0, 0, XALU, 32'h0);
        cyc(0, 32'h0, 0, 3'd1, 0, 2'd0, 0, 0, 0, XRD, 32'h0);
        cyc(0, 32'h0, 0, 3'd2, 0, 2'd0, 0, 0, 0, XN, 32'h0);
        cyc(0, 32'h0, 0, 3'd4, 1, 2'd0, 1, 0, 0, XRD, 32'h0);
        // beq taken
        cyc(0, 32'h1022FFFF, 1, 3'd0, 0, 2'd0, 0, 0, 0, XN, 32'h0);
        cyc(0, 32'h1022FFFF, 1, 3'd1, 0, 2'd0, 0, 0, 0, XIMM, 32'hFFFFFFFF);
        cyc(0, 32'h1022FFFF, 1, 3'd2, 1, 2'd2, 0, 0, 0, XIMM, 32'hFFFFFFFF);
        // beq not taken
        cyc(0, 32'h1022FFFF, 0, 3'd0, 0, 2'd0, 0, 0, 0, XN, 32'h0);
        cyc(0, 32'h1022FFFF, 0, 3'd1, 0, 2'd0, 0, 0, 0, XN, 32'h0);
        cyc(0, 32'h1022FFFF, 0, 3'd2, 1, 2'd0, 0, 0, 0, XN, 32'h0);
        // bne taken (zero=0)
        cyc(0, 32'h1422FFFF, 0, 3'd0, 0, 2'd0, 0, 0, 0, XN, 32'h0);
        cyc(0, 32'h1422FFFF, 0, 3'd1, 0, 2'd0, 0, 0, 0, XN, 32'h0);
        cyc(0, 32'h1422FFFF, 0, 3'd2, 1, 2'd2, 0, 0, 0, XN, 32'h0);
        // lw
        cyc(0, 32'h8C430004, 0, 3'd0, 0, 2'd0, 0, 0, 0, XN, 32'h0);
        cyc(0, 32'h8C430004, 0, 3'd1, 0, 2'd0, 0, 0, 0, XRT, 32'd3);
        cyc(0, 32'h8C430004, 0, 3'd2, 0, 2'd0, 0, 0, 0, XIMM, 32'd4);
        cyc(0, 32'h8C430004, 0, 3'd3, 0, 2'd0, 0, 0, 0, XN, 32'h0);
        cyc(0, 32'h8C430004, 0, 3'd4, 1, 2'd0, 1, 0, 0, XWS, 32'd2);
        // j
        cyc(0, 32'h08000010, 0, 3'd0, 0, 2'd0, 0, 0, 0, XN, 32'h0);
        cyc(0, 32'h08000010, 0, 3'd1, 1, 2'd3, 0, 0, 0, XADR, 32'h10);
        // jr $31
        cyc(0, 32'h03E00008, 0, 3'd0, 0, 2'd0, 0, 0, 0, XN, 32'h0);
        cyc(0, 32'h03E00008, 0, 3'd1, 1, 2'd1, 0, 0, 0, XN, 32'h0);
        // addi (sign-extended) and ori (zero-extended)
        cyc(0, 32'h20038001, 0, 3'd0, 0, 2'd0, 0, 0, 0, XN, 32'h0);
        cyc(0, 32'h20038001, 0, 3'd1, 0, 2'd0, 0, 0, 0, XN, 32'h0);
        cyc(0, 32'h20038001, 0, 3'd2, 0, 2'd0, 0, 0, 0, XIMM, 32'hFFFF8001);
        cyc(0, 32'h20038001, 0, 3'd4, 1, 2'd0, 1, 0, 0, XWS, 32'd1);
        cyc(0, 32'h34038001, 0, 3'd0, 0, 2'd0, 0, 0, 0, XN, 32'h0);
        cyc(0, 32'h34038001, 0, 3'd1, 0, 2'd0, 0, 0, 0, XN, 32'h0);
        cyc(0, 32'h34038001, 0, 3'd2, 0, 2'd0, 0, 0, 0, XIMM, 32'h00008001);
        cyc(0, 32'h34038001, 0, 3'd4, 1, 2'd0, 1, 0, 0, XWS, 32'd1);
        // unknown opcode, unknown funct
        cyc(0, 32'hFC000000, 0, 3'd0, 0, 2'd0, 0, 0, 0, XN, 32'h0);
        cyc(0, 32'hFC000000, 0, 3'd1, 1, 2'd0, 0, 0, 1, XN, 32'h0);
        cyc(0, 32'h0000003F, 0, 3'd0, 0, 2'd0, 0, 0, 0, XN, 32'h0);
        cyc(0, 32'h0000003F, 0, 3'd1, 1, 2'd0, 0, 0, 1, XN, 32'h0);
        // jal
        cyc(0, 32'h0C000004, 0, 3'd0, 0, 2'd0, 0, 0, 0, XN, 32'h0);
`ifdef MIPS_JAL_EN
        cyc(0, 32'h0C000004, 0, 3'd1, 0, 2'd0, 0, 0, 0, XN, 32'h0);
        cyc(0, 32'h0C000004, 0, 3'd4, 1, 2'd3, 1, 0, 0, XWS, 32'd3);
`else
        cyc(0, 32'h0C000004, 0, 3'd1, 1, 2'd0, 0, 0, 1, XN, 32'h0);
`endif
        // sw aborted by reset in MEM, then a full sw
        cyc(0, 32'hAC430008, 0, 3'd0, 0, 2'd0, 0, 0, 0, XN, 32'h0);
        cyc(0, 32'hAC430008, 0, 3'd1, 0, 2'd0, 0, 0, 0, XN, 32'h0);
        cyc(0, 32'hAC430008, 0, 3'd2, 0, 2'd0, 0, 0, 0, XN, 32'h0);
        cyc(1, 32'hAC430008, 0, 3'd3, 0, 2'd0, 0, 0, 0, XN, 32'h0);
        cyc(0, 32'hAC430008, 0, 3'd0, 0, 2'd0, 0, 0, 0, XALU, 32'h0);
        cyc(0, 32'hAC430008, 0, 3'd1, 0, 2'd0, 0, 0, 0, XN, 32'h0);
        cyc(0, 32'hAC430008, 0, 3'd2, 0, 2'd0, 0, 0, 0, XIMM, 32'd8);
        cyc(0, 32'hAC430008, 0, 3'd3, 1, 2'd0, 0, 1, 0, XN, 32'h0);
        cyc(0, 32'h00000000, 0, 3'd0, 0, 2'd0, 0, 0, 0, XN, 32'h0);

        for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge clka);
        #1;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain got=%0d pending want=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mips_ctrl.md
MIPS_CTRL -- requirements
Module: mips_ctrl

Interface
REQ-001 SHALL have ports: clka  in  1  system clock, all state on rising edge.
REQ-002 SHALL have ports: rsta  in  1  reset, synchronous, active-high.
REQ-003 SHALL have ports: Inst  in  32  instruction word from fetch ROM, valid in the cycle after PC changes.
REQ-004 SHALL have ports: zero  in  1  ALU zero flag, sampled in EX.
REQ-005 SHALL have ports: PC_s  out  2  next-PC select: 00 seq, 01 R_Data_A, 10 branch, 11 jump.
REQ-006 SHALL have ports: pc_we  out  1  PC update strobe, one cycle per instruction.
REQ-007 SHALL have ports: rs/rt/rd  out  5 each  register fields of the latched IR.
REQ-008 SHALL have ports: imm_data  out  32  extended immediate; addressa  out  26  jump target field.
REQ-009 SHALL have ports: alu_op  out  4  ALU function; alu_src  out  1  0=rt, 1=imm.
REQ-010 SHALL have ports: reg_we  out  1; w_sel  out  2  dest/data select (00 rd/ALU, 01 rt/ALU, 10 rt/mem, 11 $31/PC_new).
REQ-011 SHALL have ports: mem_we  out  1  data-memory write; illegal  out  1  one-cycle unknown-opcode pulse; state  out  3  current FSM state.

Function
REQ-012 SHALL implement FSM IF(0), ID(1), EX(2), MEM(3), WB(4), one state per clka cycle.
REQ-013 SHALL latch Inst into IR on the IF->ID transition; all field outputs SHALL come from IR only.
REQ-014 SHALL sign-extend imm for addi/lw/sw/beq/bne and zero-extend for andi/ori.
REQ-015 SHALL sequence: R-type ID-EX-WB-IF; addi/andi/ori ID-EX-WB-IF; lw ID-EX-MEM-WB-IF; sw ID-EX-MEM-IF; beq/bne ID-EX-IF; j and jr ID-IF.
REQ-016 SHALL assert pc_we for exactly one cycle, in the last state of each instruction.
REQ-017 SHALL drive PC_s with pc_we: 11 for j, 01 for jr, 10 for beq with zero=1 or bne with zero=0, else 00.
REQ-018 SHALL hold PC_s at 00 whenever pc_we=0.
REQ-019 SHALL assert reg_we only in WB and mem_we only in MEM for sw.
REQ-020 SHALL treat an unknown opcode or funct in ID as illegal: pulse illegal, assert pc_we with PC_s=00, return to IF, no reg_we or mem_we.
REQ-021 SHALL decode all-zero Inst (sll $0) as a NOP: an R-type that writes $0 only.
REQ-022 SHALL complete each instruction in 2 to 5 cycles, with no overlap between instructions.

Reset
REQ-023 SHALL, when rsta=1 at a rising edge, enter IF, clear IR to 0, and force pc_we, reg_we, mem_we and illegal to 0, PC_s to 00 and alu_op to 0.
REQ-024 SHALL abort any in-flight instruction when rsta is asserted mid-instruction, with no partial register or memory write.

Configuration
REQ-025 SHALL, with MIPS_JAL_EN defined, decode jal (opcode 000011) as ID-WB-IF, with reg_we and w_sel=11 in WB, and pc_we with PC_s=11 in WB.
REQ-026 SHALL, without MIPS_JAL_EN, treat jal as illegal per REQ-020.

Structure
REQ-027 SHALL take opcode/funct constants, state encoding, alu_op codes and w_sel codes from shared package mips_pkg.
REQ-028 SHALL place the combinational IR-to-control decode in sub-module mips_decode; the FSM and IR stay in mips_ctrl.

Verification
REQ-029 SHALL verify: rsta held 2 cycles, then Inst=0x00000000 -> state IF,ID,EX,WB,IF; single pc_we with PC_s=00; reg_we with rd=0.
REQ-030 SHALL verify: Inst=0x1022FFFF (beq) with zero=1 -> EX pc_we=1, PC_s=10, imm_data=0xFFFFFFFF; with zero=0 -> PC_s=00.
REQ-031 SHALL verify: Inst=0x8C430004 (lw) -> 5 cycles, reg_we in WB with w_sel=10, rt=3, imm_data=4; mem_we never set.
REQ-032 SHALL verify: Inst=0x08000010 (j) -> ID pc_we=1, PC_s=11, addressa=0x0000010.
REQ-033 SHALL verify: Inst=0xFC000000 -> illegal pulse in ID, pc_we with PC_s=00; 0x0C000004 gives the same without MIPS_JAL_EN, and w_sel=11 with reg_we in WB with it.
REQ-034 SHALL verify: rsta asserted in MEM of sw (0xAC430008) -> next state IF, mem_we=0 at and after the reset edge.
